// File: rtl/alien_march_controller.sv
// Formation march controller: steps the shared alien offset every step_period frames,
// bounces and descends at the screen edges, speeds up as aliens die, flags invasion/clear.
module alien_march_controller #(
  parameter int NUM_ROWS           = 2,
  parameter int NUM_COLUMNS        = 4,
  parameter int ALIEN_SPACING_X    = 64,
  parameter int ALIEN_SPACING_Y    = 32,
  parameter int ALIEN_WIDTH        = 32,
  parameter int ALIEN_HEIGHT       = 16,
  parameter int INITIAL_POSITION_X = 100,
  parameter int INITIAL_POSITION_Y = 50,
  parameter int SCREEN_LEFT        = 0,
  parameter int SCREEN_RIGHT       = 640,
  parameter int INVADE_Y           = 400,
  parameter int STEP_X             = 10,
  parameter int STEP_Y             = 16,
  parameter int MIN_PERIOD         = 2,
  parameter int PERIOD_PER_ALIEN   = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  frame_tick,
  input  logic                                  enable,
  input  logic [NUM_ROWS-1:0][NUM_COLUMNS-1:0]  alive_matrix,
  output logic signed [15:0]                    offset_x,
  output logic [15:0]                           offset_y,
  output logic                                  movement_direction,
  output logic                                  step_pulse,
  output logic                                  descend_pulse,
  output logic [15:0]                           step_period,
  output logic                                  invaded,
  output logic                                  cleared
);

  localparam int COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [15:0] RESET_PERIOD =
    16'(MIN_PERIOD + NUM_ROWS * NUM_COLUMNS * PERIOD_PER_ALIEN);

  typedef enum logic [1:0] {WAIT, STEP, HALT} state_t;

  state_t      state;
  logic [15:0] frame_cnt;

  logic [NUM_COLUMNS-1:0] col_any;
  logic [NUM_ROWS-1:0]    row_any;
  logic [COL_W-1:0]       lcol;
  logic [COL_W-1:0]       rcol;
  logic [ROW_W-1:0]       brow;
  logic [15:0]            alive_cnt;

  logic signed [16:0] left_edge;
  logic signed [16:0] right_edge;
  logic signed [16:0] bottom_next;
  logic               hit_edge;
  logic               will_invade;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    col_any   = '0;
    row_any   = '0;
    alive_cnt = '0;
    lcol      = '0;
    rcol      = '0;
    brow      = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLUMNS; c++) begin
        col_any[c] = col_any[c] | alive_matrix[r][c];
        row_any[r] = row_any[r] | alive_matrix[r][c];
        alive_cnt  = alive_cnt + 16'(alive_matrix[r][c]);
      end
    end
    for (int c = NUM_COLUMNS - 1; c >= 0; c--) begin
      if (col_any[c]) lcol = COL_W'(c);
    end
    for (int c = 0; c < NUM_COLUMNS; c++) begin
      if (col_any[c]) rcol = COL_W'(c);
    end
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (row_any[r]) brow = ROW_W'(r);
    end
  end

  // Edges of the living part of the formation; bottom_next is the bottom after a descend.
  always_comb begin
    left_edge   = 17'(INITIAL_POSITION_X + int'(offset_x) + int'(lcol) * ALIEN_SPACING_X);
    right_edge  = 17'(INITIAL_POSITION_X + int'(offset_x) + int'(rcol) * ALIEN_SPACING_X
                      + ALIEN_WIDTH);
    bottom_next = 17'(INITIAL_POSITION_Y + int'(offset_y) + STEP_Y
                      + int'(brow) * ALIEN_SPACING_Y + ALIEN_HEIGHT);
    hit_edge    = movement_direction ? (int'(right_edge) + STEP_X > SCREEN_RIGHT)
                                     : (int'(left_edge) - STEP_X < SCREEN_LEFT);
    will_invade = int'(bottom_next) >= INVADE_Y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= WAIT;
      frame_cnt          <= '0;
      offset_x           <= '0;
      offset_y           <= '0;
      movement_direction <= 1'b1;
      step_pulse         <= 1'b0;
      descend_pulse      <= 1'b0;
      step_period        <= RESET_PERIOD;
      invaded            <= 1'b0;
      cleared            <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      step_pulse    <= 1'b0;
      descend_pulse <= 1'b0;
      unique case (state)
        WAIT: begin
          if (frame_tick && enable) begin
            if (frame_cnt == step_period - 16'd1) begin
              frame_cnt <= '0;
              state     <= STEP;
            end else begin
              frame_cnt <= frame_cnt + 16'd1;
            end
          end
        end
        STEP: begin
          if (alive_cnt == '0) begin
            cleared <= 1'b1;
            state   <= HALT;
          end else begin
            step_pulse  <= 1'b1;
            step_period <= 16'(MIN_PERIOD + int'(alive_cnt) * PERIOD_PER_ALIEN);
            if (hit_edge) begin
              descend_pulse      <= 1'b1;
              offset_y           <= offset_y + 16'(STEP_Y);
              movement_direction <= ~movement_direction;
              if (will_invade) begin
                invaded <= 1'b1;
                state   <= HALT;
              end else begin
                state <= WAIT;
              end
            end else begin
              offset_x <= movement_direction ? offset_x + 16'(STEP_X)
                                             : offset_x - 16'(STEP_X);
              state    <= WAIT;
            end
          end
        end
        HALT:    state <= HALT;
        default: state <= WAIT;
      endcase
    end
  end

endmodule
